// File: rtl/multi_edge_pkg.sv
// Shared definitions for multi_edge_detector: per-channel FSM state encoding,
// edge-mode constants and the tick decode helper used by every channel.
// Optional build macro consumed elsewhere: MULTI_EDGE_DEBOUNCE_EN.
package multi_edge_pkg;

  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_ZERO = 3'd1;
  localparam logic [2:0] ST_RISE = 3'd2;
  localparam logic [2:0] ST_ONE  = 3'd3;
  localparam logic [2:0] ST_FALL = 3'd4;

  typedef enum logic [2:0] {
    S_INIT = ST_INIT,
    S_ZERO = ST_ZERO,
    S_RISE = ST_RISE,
    S_ONE  = ST_ONE,
    S_FALL = ST_FALL
  } state_t;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Moore decode: only the one-cycle RISE/FALL states can pulse, gated by mode.
  function automatic logic tick_decode(input state_t st, input logic [1:0] m);
    logic hit;
    hit = 1'b0;
    if (m != MODE_OFF) begin
      if (st == S_RISE && (m == MODE_RISE || m == MODE_BOTH)) hit = 1'b1;
      if (st == S_FALL && (m == MODE_FALL || m == MODE_BOTH)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/multi_edge_detector_edge_channel.sv
// One channel: synchroniser, optional debounce (MULTI_EDGE_DEBOUNCE_EN),
// five-state edge FSM and registered-state tick decode.
// Tick latency SYNC_STAGES+1 cycles from sampling (+DEBOUNCE_CYCLES with debounce).
module edge_channel
  import multi_edge_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       level,
  input  logic [1:0] mode,
  output logic       tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] prime_q;
  logic                   raw;
  logic                   primed;
  logic                   s;
  state_t                 state_q;
  state_t                 state_d;

  assign raw    = sync_q[SYNC_STAGES-1];
  // The synchroniser resets to 0, so its output is meaningless until it has
  // been refilled with real samples; the FSM stays in INIT until then so a
  // level already high at reset release is not mistaken for a rising edge.
  assign primed = prime_q[SYNC_STAGES-1];

  // Synchroniser chain plus a parallel "filled" marker chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= '0;
      prime_q <= '0;
    end else begin
      sync_q  <= SYNC_STAGES'({sync_q, level});
      prime_q <= SYNC_STAGES'({prime_q, 1'b1});
    end
  end

`ifdef MULTI_EDGE_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic          deb_q;
  logic [CW-1:0] cnt_q;

  // While in INIT the debounced level follows raw directly, so the FSM's
  // initial ZERO/ONE choice agrees with the value it will track afterwards.
  assign s = (state_q == S_INIT) ? raw : deb_q;

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else if (state_q == S_INIT) begin
      deb_q <= raw;
      cnt_q <= '0;
    end else if (raw != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_q <= raw;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end
`else
  assign s = raw;

  // The stability window has no meaning without debounce; kept so both builds
  // share one parameter list.
  if (DEBOUNCE_CYCLES < 1) begin : g_debounce_unused
  end
`endif

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  // Next-state logic and tick decode from the registered state.
  always_comb begin
    state_d = state_q;
    tick    = 1'b0;
    case (state_q)
      S_INIT: if (primed) state_d = s ? S_ONE : S_ZERO;
      S_ZERO: if (s)      state_d = S_RISE;
      S_RISE: state_d = s ? S_ONE : S_FALL;
      S_ONE:  if (!s)     state_d = S_FALL;
      S_FALL: state_d = s ? S_RISE : S_ZERO;
      default: state_d = S_INIT;
    endcase
    tick = tick_decode(state_q, mode) & ~reset;
  end

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector with sticky pending/missed flags and irq.
// tick: SYNC_STAGES+1 cycles after sampling (+DEBOUNCE_CYCLES if MULTI_EDGE_DEBOUNCE_EN);
// pending/missed one cycle later. No backpressure: events arriving while pending is set are flagged missed.
module multi_edge_detector
  import multi_edge_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   level,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   tick,
  output logic [CHANNELS-1:0]   pending,
  output logic [CHANNELS-1:0]   missed,
  output logic                  irq
);

  logic [CHANNELS-1:0] pending_q;
  logic [CHANNELS-1:0] missed_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clock (clock),
      .reset (reset),
      .level (level[i]),
      .mode  (mode[2*i +: 2]),
      .tick  (tick[i])
    );
  end

  // Sticky flags: a new event beats a same-cycle clear, and a clear that
  // coincides with an event leaves missed untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= '0;
      missed_q  <= '0;
    end else begin
      pending_q <= tick | (pending_q & ~clear);
      missed_q  <= (tick & pending_q) | (missed_q & ~(clear & ~tick));
    end
  end

  // Outputs read as zero for the whole reset window, including its first cycle.
  assign pending = pending_q & ~{CHANNELS{reset}};
  assign missed  = missed_q  & ~{CHANNELS{reset}};
  assign irq     = |pending;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector (CHANNELS=4, SYNC_STAGES=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_multi_edge_detector;

  localparam int CH  = 4;
  localparam int SS  = 2;
  localparam int DBC = 4;
`ifdef MULTI_EDGE_DEBOUNCE_EN
  localparam int DB = DBC;
`else
  localparam int DB = 0;
`endif
  // Steps from changing level to the step after which tick is visible.
  localparam int LAT = SS + 1 + DB;

  logic              clock;
  logic              reset;
  logic [CH-1:0]     level;
  logic [2*CH-1:0]   mode;
  logic [CH-1:0]     clear;
  logic [CH-1:0]     tick;
  logic [CH-1:0]     pending;
  logic [CH-1:0]     missed;
  logic              irq;

  int n_checks = 0;
  int n_pass   = 0;

  multi_edge_detector #(
    .CHANNELS        (CH),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DBC)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .level   (level),
    .mode    (mode),
    .clear   (clear),
    .tick    (tick),
    .pending (pending),
    .missed  (missed),
    .irq     (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int cnt;
    int at;

    reset = 1'b1;
    level = 4'b0001;
    mode  = 8'hFF;
    clear = '0;
    step(3);
    check("rst_tick",    32'(tick),    0);
    check("rst_pending", 32'(pending), 0);
    check("rst_missed",  32'(missed),  0);
    check("rst_irq",     32'(irq),     0);

    // Release with ch0 already high: no event on any channel.
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("init_no_tick", 32'(tick), 0);
    end
    check("init_irq", 32'(irq), 0);

    // ch0 rising-only: falling edge silent, rising edge ticks at fixed latency.
    mode     = 8'hFD;
    level[0] = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      step(1);
      check("ch0_fall_quiet", 32'(tick), 0);
    end
    level[0] = 1'b1;
    for (int i = 1; i <= LAT + 1; i++) begin
      step(1);
      check("ch0_rise_tick", 32'(tick), (i == LAT) ? 32'h1 : 32'h0);
      check("ch0_pending", 32'(pending), (i > LAT) ? 32'h1 : 32'h0);
    end
    check("ch0_irq",    32'(irq),    1);
    check("ch0_missed", 32'(missed), 0);
    clear = 4'b0001;
    step(1);
    clear = '0;
    check("ch0_clear",     32'(pending), 0);
    check("ch0_clear_irq", 32'(irq),     0);

    // ch1 falling-only: 5-cycle pulse gives exactly one tick, on the fall.
    mode     = 8'hF9;
    cnt      = 0;
    at       = 0;
    level[1] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 6) level[1] = 1'b0;
      step(1);
      if (tick[1]) begin
        cnt++;
        at = i;
      end
    end
    check("ch1_tick_count", 32'(cnt), 1);
    check("ch1_tick_pos",   32'(at),  32'(LAT + 5));
    check("ch1_pending",    32'(pending), 32'h2);
    clear = 4'b0010;
    step(1);
    clear = '0;

    // ch2 rising-only: two events without clear -> missed.
    mode = 8'hD9;
    for (int p = 0; p < 2; p++) begin
      level[2] = 1'b1;
      step(LAT + 2);
      level[2] = 1'b0;
      step(LAT + 2);
      check("ch2_pending", 32'(pending[2]), 1);
      check("ch2_missed",  32'(missed[2]),  (p == 1) ? 32'h1 : 32'h0);
    end
    // Third event with clear in the same cycle: both flags stay set.
    level[2] = 1'b1;
    step(LAT);
    check("ch2_third_tick", 32'(tick), 32'h4);
    clear = 4'b0100;
    step(1);
    clear = '0;
    check("ch2_set_wins_pending", 32'(pending[2]), 1);
    check("ch2_set_wins_missed",  32'(missed[2]),  1);
    level[2] = 1'b0;
    step(LAT + 2);

    // Reset one cycle ahead of a ch3 tick discards the event and all flags.
    level[3] = 1'b1;
    step(LAT - 1);
    reset = 1'b1;
    #1;
    check("rst_mid_irq",     32'(irq),     0);
    check("rst_mid_pending", 32'(pending), 0);
    step(1);
    check("rst_evt_tick",    32'(tick),    0);
    check("rst_evt_pending", 32'(pending), 0);
    check("rst_evt_missed",  32'(missed),  0);
    check("rst_evt_irq",     32'(irq),     0);
    reset = 1'b0;
    cnt   = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (tick != 0) cnt++;
    end
    check("post_rst_no_tick", 32'(cnt), 0);

`ifdef MULTI_EDGE_DEBOUNCE_EN
    // ch3 rising-only: 3-cycle glitch filtered, 4-cycle pulse accepted.
    mode     = 8'h59;
    level[3] = 1'b0;
    step(LAT + 4);
    cnt      = 0;
    level[3] = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      if (i == 4) level[3] = 1'b0;
      step(1);
      if (tick[3]) cnt++;
    end
    check("db_glitch", 32'(cnt), 0);
    cnt      = 0;
    level[3] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 5) level[3] = 1'b0;
      step(1);
      if (tick[3]) cnt++;
    end
    check("db_stable", 32'(cnt), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
